// File: rtl/median_pkg.sv
// Shared types and defaults for the median filter pipeline.
// The window type is used wherever a whole 3x3 neighbourhood is handled
// as one value. Module ports stay flat so the sorters can pick rows or
// columns freely.
package median_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

  // Indexed [row][col]. Row 0 is the oldest line and col 0 the oldest column.
  typedef pixel_t [2:0][2:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage, addressed by column.
// The read is combinational, so a pixel written on this beat is returned
// only on a later beat: read-before-write at the same address.
// The column address of the next beat depends on that beat's sof, which is
// not known one cycle early. For that reason the read cannot be registered
// without adding a clock of latency.
module line_buffer
  import median_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  // Storage is deliberately not reset; stale contents are never used by a
  // valid window because two full lines are written before row 2 starts.
  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Store the incoming pixel at its column on every accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster stream to 3x3 neighbourhood generator.
// Two chained line buffers supply the two older rows of the incoming column.
// A 3x3 shift window is advanced once per accepted pixel.
// A window is flagged valid only when it lies completely inside the image.
module window_3x3_gen
  import median_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEFAULT,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] win_r0c0,
  output logic [PIX_W-1:0] win_r0c1,
  output logic [PIX_W-1:0] win_r0c2,
  output logic [PIX_W-1:0] win_r1c0,
  output logic [PIX_W-1:0] win_r1c1,
  output logic [PIX_W-1:0] win_r1c2,
  output logic [PIX_W-1:0] win_r2c0,
  output logic [PIX_W-1:0] win_r2c1,
  output logic [PIX_W-1:0] win_r2c2,
  output logic             win_valid,
  output logic [RW-1:0]    ctr_row,
  output logic [CW-1:0]    ctr_col
);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             interior;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] new_col [3];
  logic [PIX_W-1:0] win [3][3];

  // sof overrides the counters so that the marked pixel is always (0,0).
  assign cur_col  = sof ? '0 : col;
  assign cur_row  = sof ? '0 : row;
  assign interior = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  // lb0 holds line r-1. It ages into lb1, which holds line r-2.
  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (cur_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Incoming column, oldest line at the top.
  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = pix_in;

  // Raster position of the next pixel, wrapping at line and frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Shift the window one column left and load the new column on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int y = 0; y < 3; y++) begin
        for (int x = 0; x < 3; x++) begin
          win[y][x] <= '0;
        end
      end
    end else if (pix_valid) begin
      for (int y = 0; y < 3; y++) begin
        win[y][0] <= win[y][1];
        win[y][1] <= win[y][2];
        win[y][2] <= new_col[y];
      end
    end
  end

  // Valid strobe and centre coordinates. The centre is held between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      ctr_row   <= '0;
      ctr_col   <= '0;
    end else begin
      win_valid <= pix_valid && interior;
      if (pix_valid && interior) begin
        ctr_row <= cur_row - RW'(1);
        ctr_col <= cur_col - CW'(1);
      end
    end
  end

  assign win_r0c0 = win[0][0];
  assign win_r0c1 = win[0][1];
  assign win_r0c2 = win[0][2];
  assign win_r1c0 = win[1][0];
  assign win_r1c1 = win[1][1];
  assign win_r1c2 = win[1][2];
  assign win_r2c0 = win[2][0];
  assign win_r2c1 = win[2][1];
  assign win_r2c2 = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a 4x4 instance and a minimum-size 3x3 instance.
// Stimulus tasks push the expected window for every interior pixel.
// A negedge monitor pops and compares whenever a DUT raises win_valid.
module tb_window_3x3_gen;
  import median_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, pv4, sof4;
  logic [7:0] pix4;
  logic       rst3, pv3, sof3;
  logic [7:0] pix3;
  wire window_t obs4;
  wire window_t obs3;
  wire        wv4, wv3;
  wire [1:0]  cr4, cc4, cr3, cc3;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut4 (
    .clk(clk), .rst(rst4), .pix_in(pix4), .pix_valid(pv4), .sof(sof4),
    .win_r0c0(obs4[0][0]), .win_r0c1(obs4[0][1]), .win_r0c2(obs4[0][2]),
    .win_r1c0(obs4[1][0]), .win_r1c1(obs4[1][1]), .win_r1c2(obs4[1][2]),
    .win_r2c0(obs4[2][0]), .win_r2c1(obs4[2][1]), .win_r2c2(obs4[2][2]),
    .win_valid(wv4), .ctr_row(cr4), .ctr_col(cc4)
  );

  window_3x3_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) dut3 (
    .clk(clk), .rst(rst3), .pix_in(pix3), .pix_valid(pv3), .sof(sof3),
    .win_r0c0(obs3[0][0]), .win_r0c1(obs3[0][1]), .win_r0c2(obs3[0][2]),
    .win_r1c0(obs3[1][0]), .win_r1c1(obs3[1][1]), .win_r1c2(obs3[1][2]),
    .win_r2c0(obs3[2][0]), .win_r2c1(obs3[2][1]), .win_r2c2(obs3[2][2]),
    .win_valid(wv3), .ctr_row(cr3), .ctr_col(cc3)
  );

  typedef struct {
    window_t w;
    int      r;
    int      c;
    int      cyc;
  } exp_t;

  exp_t       q0[$], q1[$], log0[$], log1[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         mr[2], mc[2];
  int         wd[2] = '{4, 3};
  int         ht[2] = '{4, 3};
  logic [7:0] img[2][4][4];
  bit         toggle_mode = 1'b0;
  bit         prevv[2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string msg);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic set_in(input int d, input bit v, input bit s, input logic [7:0] p);
    if (d == 0) begin pv4 = v; sof4 = s; pix4 = p; end
    else        begin pv3 = v; sof3 = s; pix3 = p; end
  endtask

  // Drive one accepted pixel and record the window it should complete.
  task automatic send(input int d, input logic [7:0] p, input bit s);
    exp_t e;
    set_in(d, 1'b1, s, p);
    if (s) begin mr[d] = 0; mc[d] = 0; end
    img[d][mr[d]][mc[d]] = p;
    if (mr[d] >= 2 && mc[d] >= 2) begin
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          e.w[y][x] = img[d][mr[d]-2+y][mc[d]-2+x];
      e.r = mr[d] - 1;
      e.c = mc[d] - 1;
      e.cyc = cyc + 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (mc[d] == wd[d] - 1) begin
      mc[d] = 0;
      mr[d] = (mr[d] == ht[d] - 1) ? 0 : mr[d] + 1;
    end else begin
      mc[d]++;
    end
    @(negedge clk);
  endtask

  // One idle beat on the 4x4 instance: outputs must hold and win_valid drop.
  task automatic gap();
    window_t sw;
    logic [1:0] sr, sc;
    set_in(0, 1'b0, 1'b0, 8'h00);
    sw = obs4; sr = cr4; sc = cc4;
    @(negedge clk);
    check(obs4 == sw && cr4 == sr && cc4 == sc && !wv4,
          $sformatf("gap_hold got win=%h ctr=(%0d,%0d) v=%0d want win=%h ctr=(%0d,%0d) v=0",
                    obs4, cr4, cc4, wv4, sw, sr, sc));
  endtask

  task automatic frame(input int d, input int base, input bit tog);
    for (int r = 0; r < ht[d]; r++)
      for (int c = 0; c < wd[d]; c++) begin
        send(d, 8'(base + 16*r + c), (r == 0 && c == 0));
        if (tog) gap();
      end
  endtask

  task automatic drain(input int d);
    set_in(d, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check((d == 0 ? q0.size() : q1.size()) == 0,
          $sformatf("drain dut%0d got %0d pending windows want 0", d, (d == 0 ? q0.size() : q1.size())));
  endtask

  task automatic mon(input int d);
    bit v;
    window_t w;
    int r, c;
    exp_t e, o;
    if (d == 0) begin v = wv4; w = obs4; r = cr4; c = cc4; end
    else        begin v = wv3; w = obs3; r = cr3; c = cc3; end
    if (v) begin
      if (d == 0 && toggle_mode)
        check(!prevv[0], "back_to_back got win_valid high twice want single-cycle pulses");
      o.w = w; o.r = r; o.c = c; o.cyc = cyc;
      if (d == 0) log0.push_back(o); else log1.push_back(o);
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        check(1'b0, $sformatf("unexpected dut%0d got window %h ctr=(%0d,%0d) want none", d, w, r, c));
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check(e.w == w && e.r == r && e.c == c,
              $sformatf("window dut%0d got %h ctr=(%0d,%0d) want %h ctr=(%0d,%0d)",
                        d, w, r, c, e.w, e.r, e.c));
        check(e.cyc == cyc, $sformatf("latency dut%0d got cycle %0d want %0d", d, cyc, e.cyc));
      end
    end
    prevv[d] = v;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst4 = 1'b1; rst3 = 1'b1;
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    mr = '{0, 0}; mc = '{0, 0};
    @(negedge clk);
    check(obs4 == '0 && !wv4 && cr4 == 0 && cc4 == 0,
          $sformatf("reset4 got win=%h v=%0d ctr=(%0d,%0d) want all zero", obs4, wv4, cr4, cc4));
    check(obs3 == '0 && !wv3 && cr3 == 0 && cc3 == 0,
          $sformatf("reset3 got win=%h v=%0d ctr=(%0d,%0d) want all zero", obs3, wv3, cr3, cc3));
    rst4 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // Continuous 4x4 frame, values 16*r+c.
    log0.delete();
    frame(0, 0, 1'b0);
    drain(0);
    check(log0.size() == 4, $sformatf("count_cont got %0d want 4", log0.size()));
    if (log0.size() == 4) begin
      check(log0[0].w[0][0] == 8'h00 && log0[0].w[1][1] == 8'h11 && log0[0].w[2][2] == 8'h22 &&
            log0[0].r == 1 && log0[0].c == 1,
            $sformatf("first_win got %h ctr=(%0d,%0d) want r0c0=00 r1c1=11 r2c2=22 ctr=(1,1)",
                      log0[0].w, log0[0].r, log0[0].c));
      check(log0[1].w[0][0] == 8'h01 && log0[1].w[2][2] == 8'h23 && log0[1].r == 1 && log0[1].c == 2,
            $sformatf("second_win got %h ctr=(%0d,%0d) want r0c0=01 r2c2=23 ctr=(1,2)",
                      log0[1].w, log0[1].r, log0[1].c));
    end

    // Same frame with pix_valid toggling.
    log0.delete();
    toggle_mode = 1'b1;
    frame(0, 0, 1'b1);
    drain(0);
    toggle_mode = 1'b0;
    check(log0.size() == 4, $sformatf("count_toggle got %0d want 4", log0.size()));
    if (log0.size() == 4)
      check(log0[3].w[0][0] == 8'h11 && log0[3].w[2][2] == 8'h33 && log0[3].r == 2 && log0[3].c == 2,
            $sformatf("last_win got %h ctr=(%0d,%0d) want r0c0=11 r2c2=33 ctr=(2,2)",
                      log0[3].w, log0[3].r, log0[3].c));

    // Two back-to-back frames; the second must not see frame-1 data.
    log0.delete();
    frame(0, 0, 1'b0);
    frame(0, 8'h80, 1'b0);
    drain(0);
    check(log0.size() == 8, $sformatf("count_b2b got %0d want 8", log0.size()));
    if (log0.size() == 8) begin
      check(log0[4].w[0][0] == 8'h80, $sformatf("f2_first got r0c0=%h want 80", log0[4].w[0][0]));
      for (int k = 4; k < 8; k++) begin
        ok = 1'b1;
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            ok &= log0[k].w[y][x][7];
        check(ok, $sformatf("f2_clean win%0d got %h want every pixel >= 80", k, log0[k].w));
      end
    end

    // sof at old pixel (2,1): counters resync, old (2,2) never windowed.
    log0.delete();
    for (int i = 0; i < 9; i++) send(0, 8'(16*(i/4) + i%4), (i == 0));
    frame(0, 8'h40, 1'b0);
    drain(0);
    check(log0.size() == 4, $sformatf("count_resync got %0d want 4", log0.size()));
    if (log0.size() == 4)
      check(log0[0].w[0][0] == 8'h40 && log0[0].w[2][2] == 8'h62 && log0[0].r == 1 && log0[0].c == 1,
            $sformatf("resync_first got %h ctr=(%0d,%0d) want r0c0=40 r2c2=62 ctr=(1,1)",
                      log0[0].w, log0[0].r, log0[0].c));

    // Asynchronous reset mid-row 2, then a stream without sof.
    log0.delete();
    for (int i = 0; i < 10; i++) send(0, 8'(16*(i/4) + i%4), (i == 0));
    set_in(0, 1'b0, 1'b0, 8'h00);
    #2 rst4 = 1'b1;
    #1 check(obs4 == '0 && !wv4 && cr4 == 0 && cc4 == 0,
             $sformatf("async_reset got win=%h v=%0d ctr=(%0d,%0d) want all zero", obs4, wv4, cr4, cc4));
    @(negedge clk);
    rst4 = 1'b0;
    mr[0] = 0; mc[0] = 0;
    for (int i = 0; i < 16; i++) send(0, 8'(8'h20 + 16*(i/4) + i%4), 1'b0);
    drain(0);
    check(log0.size() == 4, $sformatf("count_after_reset got %0d want 4", log0.size()));
    if (log0.size() == 4)
      check(log0[0].w[0][0] == 8'h20 && log0[0].w[1][1] == 8'h31 && log0[0].r == 1 && log0[0].c == 1,
            $sformatf("reset_first got %h ctr=(%0d,%0d) want r0c0=20 r1c1=31 ctr=(1,1)",
                      log0[0].w, log0[0].r, log0[0].c));

    // Minimum 3x3 image: one window per frame.
    log1.delete();
    frame(1, 0, 1'b0);
    frame(1, 8'h40, 1'b0);
    drain(1);
    check(log1.size() == 2, $sformatf("count_3x3 got %0d want 2", log1.size()));
    if (log1.size() == 2) begin
      check(log1[0].w[0][0] == 8'h00 && log1[0].w[1][1] == 8'h11 && log1[0].w[2][2] == 8'h22 &&
            log1[0].r == 1 && log1[0].c == 1,
            $sformatf("win_3x3 got %h ctr=(%0d,%0d) want r0c0=00 r1c1=11 r2c2=22 ctr=(1,1)",
                      log1[0].w, log1[0].r, log1[0].c));
      check(log1[1].w[0][2] == 8'h42 && log1[1].w[2][0] == 8'h60,
            $sformatf("win_3x3_f2 got %h want r0c2=42 r2c0=60", log1[1].w));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
